// File: rtl/cgp_fitness_driver_if.sv
// Controller/individual/ROM-facing signals of the fitness driver, grouped as one bundle.
// slave = the driver itself; master = the controller, individual and target ROM around it.
interface cgp_fitness_driver_if #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 10,
  parameter int ERR_W = 14
);
  logic              start;
  logic              abort;
  logic [N_OUT-1:0]  out_mask;
  logic [ERR_W-1:0]  err_limit;
  logic [N_IN-1:0]   dut_in;
  logic [N_OUT-1:0]  dut_out;
  logic [N_IN-1:0]   exp_addr;
  logic [N_OUT-1:0]  exp_data;
  logic              busy;
  logic              done;
  logic              pruned;
  logic [ERR_W-1:0]  fitness;

  modport slave (
    input  start, abort, out_mask, err_limit, dut_out, exp_data,
    output dut_in, exp_addr, busy, done, pruned, fitness
  );

  modport master (
    output start, abort, out_mask, err_limit, dut_out, exp_data,
    input  dut_in, exp_addr, busy, done, pruned, fitness
  );
endinterface

// File: rtl/cgp_fitness_driver.sv
// Sweeps all 2^N_IN vectors into the evolved individual and sums masked bit errors vs the target ROM.
// Full sweep takes 1 + 2^N_IN*(SETTLE_CYCLES+1) cycles; no backpressure, only start/abort/done handshake.
module cgp_fitness_driver #(
  parameter int N_IN          = 10,
  parameter int N_OUT         = 10,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  cgp_fitness_driver_if.slave   bus
);

  localparam int          E_W    = $clog2(N_OUT + 1);
  localparam logic [3:0]  RELOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [N_IN-1:0]    vec;
  logic [N_OUT-1:0]   mask_q;
  logic [ERR_W-1:0]   limit_q;
  logic [ERR_W-1:0]   fit_q;
  logic               busy_q;
  logic               done_q;
  logic               pruned_q;

  logic [E_W-1:0]     err;
  logic [ERR_W:0]     raw_sum;
  logic [ERR_W-1:0]   fit_sum;
  logic               hit_limit;

  always_comb begin
    err = '0;
    for (int i = 0; i < N_OUT; i++) begin
      err = err + E_W'((bus.dut_out[i] ^ bus.exp_data[i]) & mask_q[i]);
    end
    raw_sum   = {1'b0, fit_q} + (ERR_W + 1)'(err);
    // Saturate rather than wrap so an undersized accumulator can never look fitter.
    fit_sum   = raw_sum[ERR_W] ? '1 : raw_sum[ERR_W-1:0];
    hit_limit = (limit_q != '0) && (fit_sum >= limit_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      vec      <= '0;
      mask_q   <= '0;
      limit_q  <= '0;
      fit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pruned_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        // Also swallows a simultaneous start while idle.
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              mask_q   <= bus.out_mask;
              limit_q  <= bus.err_limit;
              fit_q    <= '0;
              pruned_q <= 1'b0;
              vec      <= '0;
              cnt      <= RELOAD;
              busy_q   <= 1'b1;
              state    <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == 4'd0) state <= SAMPLE;
            else             cnt   <= cnt - 4'd1;
          end
          SAMPLE: begin
            fit_q <= fit_sum;
            if (hit_limit) begin
              pruned_q <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= FINISH;
            end else if (&vec) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FINISH;
            end else begin
              vec   <= vec + 1'b1;
              cnt   <= RELOAD;
              state <= SETTLE;
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dut_in   = vec;
  assign bus.exp_addr = vec;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pruned   = pruned_q;
  assign bus.fitness  = fit_q;

endmodule

// File: doc/cgp_fitness_driver.md
Name: cgp_fitness_driver

Overview:
- Stimulus/response end of the evolved LUT grid: drives the 10 primary inputs of the evolved combinational individual and samples its 10 outputs.
- Sweeps every input vector, compares the sampled outputs against a target truth table held in external synchronous ROM, and accumulates a bit-error count as the fitness score.
- Sits between the evolution controller (start/done handshake) and the placed individual.

Parameters:
- N_IN, 10, individual input count; the sweep covers 2^N_IN vectors.
- N_OUT, 10, individual output count.
- SETTLE_CYCLES, 2, cycles the vector is held before sampling; legal range 1..15.
- ERR_W, 14, width of the error accumulator; must satisfy 2^ERR_W > N_OUT*2^N_IN.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin an evaluation; honoured only in IDLE.
- abort  in  1  cancels a run in progress; return to IDLE with no done pulse.
- out_mask  in  N_OUT  output bits that count toward fitness; latched on an accepted start.
- err_limit  in  ERR_W  early-termination threshold; latched on start; 0 disables the threshold.
- dut_in  out  N_IN  vector driven to the individual inputs.
- dut_out  in  N_OUT  individual outputs.
- exp_addr  out  N_IN  target ROM address, always equal to dut_in.
- exp_data  in  N_OUT  ROM data; valid one cycle after exp_addr changes.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when the result is final.
- pruned  out  1  result was cut short by err_limit; held until the next accepted start.
- fitness  out  ERR_W  accumulated error count; held until the next accepted start.

Behaviour:
- Reset: state IDLE; dut_in, exp_addr, fitness, busy, done and pruned all 0; settle counter 0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE, when start=1: latch mask and limit; clear fitness and pruned; set dut_in=0; go to SETTLE with counter=SETTLE_CYCLES-1.
- SETTLE: decrement the counter each cycle; go to SAMPLE on the cycle the counter is 0. Vector hold time is therefore exactly SETTLE_CYCLES cycles before the SAMPLE cycle.
- SAMPLE:
  - Compute e = popcount((dut_out XOR exp_data) AND mask).
  - fitness <= fitness + e. The add saturates at all-ones; with legal ERR_W saturation is never reached.
  - If err_limit != 0 and (fitness + e) >= err_limit: set pruned=1 and go to FINISH.
  - Else if dut_in == all-ones: go to FINISH.
  - Else: dut_in <= dut_in+1 and go to SETTLE with the counter reloaded.
- FINISH: done=1 for exactly one cycle; busy drops in the same cycle; return to IDLE.
- Total latency for a full sweep: 1 + 2^N_IN*(SETTLE_CYCLES+1) cycles from the start cycle to the done cycle.
- start while busy: ignored; it has no effect on the latched mask or limit.
- abort, from any non-IDLE state: next cycle is IDLE and busy=0, with no done pulse. fitness and pruned keep their partial values but are undefined to the user. dut_in keeps its value.
- abort and start in the same IDLE cycle: abort wins and the start is dropped.
- Reset mid-run: everything returns to the reset values and no done pulse is issued.
- mask=0: every vector adds 0; fitness=0 and pruned=0 at done.
- dut_in is registered, so no glitches reach the individual. exp_data is sampled only in SAMPLE.

Test Plan:
- Identity target: ROM[a]=a, individual models out=in, mask=0x3FF, limit=0, SETTLE=2 -> done exactly 3073 cycles after start; fitness=0; pruned=0.
- Inverted target: ROM[a]=~a, same individual, mask=0x3FF -> fitness=10240; no saturation.
- Masking: inverted target with mask=0x001 -> fitness=1024; with mask=0 -> fitness=0.
- Early exit: inverted target, mask=0x3FF, limit=25 -> pruned=1 and fitness=30; done in the SAMPLE cycle of vector 2 plus one, with dut_in=2 at done.
- Abort: start, then abort at cycle 500 -> busy=0 next cycle, no done pulse; a following start completes a normal full sweep with correct fitness.
- Protocol: start pulses while busy ignored, giving a single done; reset asserted mid-sweep -> all outputs 0 on the next cycle; exp_addr==dut_in on every cycle.
